// File: rtl/lpif_asym2_pkg.sv
// Shared types and constants for the LPIF x16 asymmetric-2 lane packing path.
package lpif_asym2_pkg;

  localparam int LPIF_ASYM2_LANE_W = 281;
  localparam int LPIF_ASYM2_WORD_W = 2 * LPIF_ASYM2_LANE_W;

  // Packed structs fill from the MSB, so the fields are listed in reverse to land state at bit 0.
  typedef struct packed {
    logic         valid;
    logic         crc_valid;
    logic [15:0]  crc;
    logic         dvalid;
    logic [255:0] data;
    logic [1:0]   protid;
    logic [3:0]   state;
  } lpif_asym2_lane_t;

  typedef enum logic {
    LPIF_ASYM2_IDLE,
    LPIF_ASYM2_HALF
  } lpif_asym2_state_e;

  // An unused lane carries only the LPIF state of lane 0.
  function automatic lpif_asym2_lane_t lpif_asym2_idle_lane(input logic [3:0] state);
    lpif_asym2_lane_t lane;
    lane       = '0;
    lane.state = state;
    return lane;
  endfunction

endpackage

// File: rtl/lpif_asym2_lane_pack.sv
// Maps one LPIF beat onto a lane field; shared by the downstream packer and upstream unpacker.
module lpif_asym2_lane_pack
  import lpif_asym2_pkg::*;
(
  input  logic [3:0]       state,
  input  logic [1:0]       protid,
  input  logic [255:0]     data,
  input  logic             dvalid,
  input  logic [15:0]      crc,
  input  logic             crc_valid,
  output lpif_asym2_lane_t lane
);

  always_comb begin
    lane.valid     = 1'b1;
    lane.crc_valid = crc_valid;
    lane.crc       = crc;
    lane.dvalid    = dvalid;
    lane.data      = data;
    lane.protid    = protid;
    lane.state     = state;
  end

endmodule

// File: rtl/lpif_asym2_dstrm_packer.sv
// Pairs single-lane LPIF beats into two-lane words for the logic-link TX FIFO.
// Define LPIF_ASYM2_FLUSH_EN to enable the lone-beat timeout flush and its debug counter.
module lpif_asym2_dstrm_packer
  import lpif_asym2_pkg::*;
#(
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                         clk_wr,
  input  logic                         rst_wr_n,
  input  logic                         m_gen2_mode,
  input  logic [3:0]                   in_state,
  input  logic [1:0]                   in_protid,
  input  logic [255:0]                 in_data,
  input  logic                         in_dvalid,
  input  logic [15:0]                  in_crc,
  input  logic                         in_crc_valid,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LPIF_ASYM2_WORD_W-1:0] txfifo_downstream_data,
  output logic                         txfifo_push,
  input  logic                         txfifo_ready,
  output logic [7:0]                   flush_cnt_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 255) begin : g_flush_range
    $error("FLUSH_CYCLES must lie in 1..255");
  end

  lpif_asym2_state_e            state_q, state_d;
  lpif_asym2_lane_t             beat_lane, hold_q;
  logic                         rst_done_q;
  logic                         out_free;
  logic                         hold_en;
  logic                         load_out;
  logic [LPIF_ASYM2_WORD_W-1:0] word_d;

  lpif_asym2_lane_pack u_lane_pack (
    .state     (in_state),
    .protid    (in_protid),
    .data      (in_data),
    .dvalid    (in_dvalid),
    .crc       (in_crc),
    .crc_valid (in_crc_valid),
    .lane      (beat_lane)
  );

  assign out_free = !txfifo_push || txfifo_ready;

`ifdef LPIF_ASYM2_FLUSH_EN
  localparam logic [7:0] FLUSH_MAX = 8'(FLUSH_CYCLES);
  logic [7:0] cnt_q;
  logic       do_flush;
`endif

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_wr_n) begin
      state_q    <= LPIF_ASYM2_IDLE;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    in_ready = 1'b0;
    hold_en  = 1'b0;
    load_out = 1'b0;
    word_d   = {lpif_asym2_idle_lane(beat_lane.state), beat_lane};
`ifdef LPIF_ASYM2_FLUSH_EN
    do_flush = 1'b0;
`endif
    if (rst_done_q) begin
      unique case (state_q)
        LPIF_ASYM2_IDLE: begin
          if (m_gen2_mode) begin
            // The holding register is always free in IDLE, so gen2 never stalls the first beat.
            in_ready = 1'b1;
            if (in_valid) begin
              hold_en = 1'b1;
              state_d = LPIF_ASYM2_HALF;
            end
          end else begin
            in_ready = out_free;
            load_out = in_valid && out_free;
          end
        end
        LPIF_ASYM2_HALF: begin
          in_ready = out_free;
          if (in_valid && out_free) begin
            load_out = 1'b1;
            word_d   = {beat_lane, hold_q};
            state_d  = LPIF_ASYM2_IDLE;
          end
`ifdef LPIF_ASYM2_FLUSH_EN
          else if (cnt_q == FLUSH_MAX && out_free) begin
            load_out = 1'b1;
            do_flush = 1'b1;
            word_d   = {lpif_asym2_idle_lane(hold_q.state), hold_q};
            state_d  = LPIF_ASYM2_IDLE;
          end
`endif
        end
      endcase
    end
  end

  // NOTE: the holding register is pure datapath; its contents only matter in HALF, so it has no reset.
  always_ff @(posedge clk_wr) begin
    if (hold_en) hold_q <= beat_lane;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      txfifo_push            <= 1'b0;
      txfifo_downstream_data <= '0;
    end else if (out_free) begin
      txfifo_push <= load_out;
      if (load_out) txfifo_downstream_data <= word_d;
    end
  end

`ifdef LPIF_ASYM2_FLUSH_EN
  // The wait counter keeps saturating under backpressure so the flush fires on the first free cycle.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      cnt_q       <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold_en) begin
        cnt_q <= '0;
      end else if (state_q == LPIF_ASYM2_HALF && cnt_q != FLUSH_MAX) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (do_flush && flush_cnt_o != 8'hFF) flush_cnt_o <= flush_cnt_o + 8'd1;
    end
  end
`else
  assign flush_cnt_o = '0;
`endif

endmodule
